stego_decode: RTL
=================

Name: stego_decode

Overview:
- Recovers the 4096-bit hidden string from a stego image by comparing it block-by-block against the AMBTC-compressed reference image.
- Sits after the grayscale/compress/encode pipeline, as that flow's receiver: it reads both images through a shared row/col address and rebuilds the string 16 bits per 4x4 block.
- Only the green channel [15:8] is used.

Parameters:
- IMG_DIM, 64, image side in pixels (row/col are 6 bits).
- BLK, 4, block side; 16 pixels per block.
- CHUNK, 16, string bits recovered per block; string width = (IMG_DIM/BLK)^2*CHUNK = 4096.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins decode when idle
- row  out  6  pixel row address shared by both image memories
- col  out  6  pixel column address
- ref_pix  in  24  compressed-image pixel at [row,col]; valid the cycle after the address
- enc_pix  in  24  stego-image pixel at [row,col]; same timing as ref_pix
- found_string  out  4096  recovered string; block b fills bits [16b +: 16]
- busy  out  1  high from start acceptance until decode_done
- decode_done  out  1  one-cycle pulse when the last block has been stored
- err  out  1  sticky protocol-violation flag; cleared only on start or reset

Behaviour:
- Reset (asynchronous, any state): FSM returns to IDLE.
- Reset values: row=0, col=0, found_string=0, busy=0, decode_done=0, err=0.
- Block order: raster over 16x16 blocks, block b = (bi,bj), b = bi*16+bj.
- Pixel order within a block: raster, k = 4*r+c, 0..15.
- Address/data timing: the address for pixel k is driven in cycle t; its data is sampled in cycle t+1.
- IDLE: start is accepted here and ignored in every other state.
- On acceptance: found_string:=0, err:=0, busy:=1, block:=0, next state SCAN.
- SCAN, 17 cycles:
  - Read ref green for k=0..15.
  - Track cmin = first k holding the minimum and cmax = first k holding the maximum; strict compares, so the earliest index wins ties.
- SKIP (combinational at the end of SCAN):
  - If cmin==cmax (uniform block), skip set = {0,1}.
  - Otherwise skip set = {0, max(cmin,cmax)}.
- EXTRACT, 17 cycles:
  - Re-read k=0..15 from both images.
  - d = enc_g - ref_g, 9-bit signed.
  - For non-skipped k, in increasing k, the n-th non-skipped pixel gives trit n (n=0..13):
    - d=0 -> trit 0.
    - d=+1 -> trit 1.
    - d=-1 -> trit 2.
    - Any other d -> trit 0 and err:=1.
  - For skipped k: if d != 0, err:=1; no trit is produced.
- CONVERT, 14 cycles:
  - Initialise acc=0 (23 bits) and pw=1 (22 bits).
  - Each cycle n: acc += trit_n*pw, then pw *= 3.
- STORE, 1 cycle:
  - found_string[16b +: 16] := acc[15:0].
  - If acc > 65535, err:=1.
- NEXT, 1 cycle: if b==255 go to DONE, otherwise b+1 and go to SCAN.
- Cycle budget: exactly 50 cycles per block.
- DONE: decode_done=1 for one cycle, busy:=0, return to IDLE. decode_done rises 12800 cycles after the start-acceptance edge.
- found_string is stable after DONE and holds until the next accepted start.
- Address stability: row/col hold their last value outside SCAN/EXTRACT.
- Arithmetic: pixel compares are unsigned 8-bit. The d computation must not wrap: 0x00 vs 0xFF gives d = -255, which is an error, not +1.

Test Plan:
- enc image identical to ref, uniform blocks (all green 0x40) -> found_string=0, err=0, decode_done exactly 12800 cycles after start.
- Block 0 ref has min at k=5 and max at k=9 (skip {0,9}). Non-skipped pixels carry d = +1,-1,+1,+1,0,+1,0,-1 then zeros -> found_string[15:0]=16'h1234, err=0.
- Uniform ref block 3 (skip {0,1}). enc green +1 at k=2 only -> found_string[63:48]=16'h0001. Adding +1 at k=0 as well sets err=1 with the same data.
- One pixel with d=+2, and separately all 14 trits =2 (value 4782968) -> err=1. The second case stores 16'h fb78 (= 4782968 mod 65536).
- rst pulsed mid-EXTRACT of block 40 -> outputs return to reset values in the same cycle. A fresh start then decodes from block 0 correctly.
- start pulsed while busy -> ignored, with no restart and no change to the done timing. A start after decode_done clears found_string and err.

Source files
------------

// File: rtl/stego_decode.sv
// rtl/stego_decode.sv - block-wise AMBTC stego string decoder
//
// Purpose: walks the 64x64 reference (AMBTC-compressed) and stego images one
// 4x4 block at a time and rebuilds 16 string bits per block. Each block takes
// 50 cycles: scan ref green for min/max (17 cycles), extract trits from enc-ref
// green differences (17), fold 14 base-3 trits into an integer (14), then store
// it (1) and advance to the next block (1).
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            one-cycle pulse, accepted only when idle
//   row, col         shared pixel address for both image memories
//   ref_pix, enc_pix pixel data, valid the cycle after the address
//   found_string     recovered string, block b at [16b +: 16]
//   busy             decode in progress
//   decode_done      one-cycle pulse after the last block is stored
//   err              sticky protocol-violation flag, cleared on start/reset
module stego_decode (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [5:0]    row,
  output logic [5:0]    col,
  input  logic [23:0]   ref_pix,
  input  logic [23:0]   enc_pix,
  output logic [4095:0] found_string,
  output logic          busy,
  output logic          decode_done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_EXTRACT, S_CONVERT, S_STORE, S_NEXT, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [7:0]      blk_q, blk_d;
  logic [5:0]      row_q, row_d, col_q, col_d;
  logic [4095:0]   found_q, found_d;
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [7:0]      min_q, min_d, max_q, max_d;
  logic [3:0]      cmin_q, cmin_d, cmax_q, cmax_d;
  logic [3:0]      n_q, n_d;
  logic [27:0]     trit_q, trit_d;
  logic [22:0]     acc_q, acc_d;
  logic [21:0]     pw_q, pw_d;

  logic [7:0]      ref_g, enc_g, blk_nxt;
  logic [8:0]      diff;
  logic [3:0]      pk, nk, skip1;
  logic [1:0]      trit_v, cur_trit;
  logic [22:0]     term;
  logic            unused_bits;

  assign ref_g   = ref_pix[15:8];
  assign enc_g   = enc_pix[15:8];
  assign unused_bits = ^{ref_pix[23:16], ref_pix[7:0], enc_pix[23:16], enc_pix[7:0]};
  // Zero-extend before subtracting so 0x00-0xFF reads as -255, never +1.
  assign diff    = {1'b0, enc_g} - {1'b0, ref_g};
  // Data arriving this cycle belongs to the pixel addressed last cycle.
  assign pk      = cnt_q[3:0] - 4'd1;
  assign nk      = cnt_q[3:0] + 4'd1;
  assign blk_nxt = blk_q + 8'd1;
  // Uniform block (both indices still 0) skips pixels 0 and 1.
  assign skip1   = (cmin_q == cmax_q) ? 4'd1 : ((cmin_q > cmax_q) ? cmin_q : cmax_q);
  assign cur_trit = trit_q[{cnt_q[3:0], 1'b0} +: 2];
  assign term    = (cur_trit == 2'd1) ? {1'b0, pw_q} :
                   (cur_trit == 2'd2) ? {pw_q, 1'b0} : 23'd0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    row_d   = row_q;
    col_d   = col_q;
    found_d = found_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    min_d   = min_q;
    max_d   = max_q;
    cmin_d  = cmin_q;
    cmax_d  = cmax_q;
    n_d     = n_q;
    trit_d  = trit_q;
    acc_d   = acc_q;
    pw_d    = pw_q;
    trit_v  = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          found_d = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          blk_d   = 8'd0;
          cnt_d   = 5'd0;
          row_d   = 6'd0;
          col_d   = 6'd0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q != 5'd0) begin
          if (pk == 4'd0) begin
            min_d  = ref_g;
            max_d  = ref_g;
            cmin_d = 4'd0;
            cmax_d = 4'd0;
          end else begin
            // Strict compares keep the earliest index on ties.
            if (ref_g < min_q) begin
              min_d  = ref_g;
              cmin_d = pk;
            end
            if (ref_g > max_q) begin
              max_d  = ref_g;
              cmax_d = pk;
            end
          end
        end
        if (cnt_q < 5'd15) begin
          row_d = {blk_q[7:4], nk[3:2]};
          col_d = {blk_q[3:0], nk[1:0]};
        end else if (cnt_q == 5'd16) begin
          row_d   = {blk_q[7:4], 2'b00};
          col_d   = {blk_q[3:0], 2'b00};
          cnt_d   = 5'd0;
          n_d     = 4'd0;
          state_d = S_EXTRACT;
        end
      end
      S_EXTRACT: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q != 5'd0) begin
          if (pk == 4'd0 || pk == skip1) begin
            if (diff != 9'd0) err_d = 1'b1;
          end else begin
            case (diff)
              9'h000:  trit_v = 2'd0;
              9'h001:  trit_v = 2'd1;
              9'h1ff:  trit_v = 2'd2;
              default: begin
                trit_v = 2'd0;
                err_d  = 1'b1;
              end
            endcase
            trit_d[{n_q, 1'b0} +: 2] = trit_v;
            n_d = n_q + 4'd1;
          end
        end
        if (cnt_q < 5'd15) begin
          row_d = {blk_q[7:4], nk[3:2]};
          col_d = {blk_q[3:0], nk[1:0]};
        end else if (cnt_q == 5'd16) begin
          cnt_d   = 5'd0;
          acc_d   = 23'd0;
          pw_d    = 22'd1;
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        acc_d = acc_q + term;
        pw_d  = pw_q + {pw_q[20:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd13) begin
          cnt_d   = 5'd0;
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        found_d[{blk_q, 4'b0000} +: 16] = acc_q[15:0];
        if (|acc_q[22:16]) err_d = 1'b1;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (blk_q == 8'd255) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          blk_d   = blk_nxt;
          cnt_d   = 5'd0;
          row_d   = {blk_nxt[7:4], 2'b00};
          col_d   = {blk_nxt[3:0], 2'b00};
          state_d = S_SCAN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      blk_q   <= 8'd0;
      row_q   <= 6'd0;
      col_q   <= 6'd0;
      found_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      min_q   <= 8'd0;
      max_q   <= 8'd0;
      cmin_q  <= 4'd0;
      cmax_q  <= 4'd0;
      n_q     <= 4'd0;
      trit_q  <= '0;
      acc_q   <= 23'd0;
      pw_q    <= 22'd1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      row_q   <= row_d;
      col_q   <= col_d;
      found_q <= found_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      min_q   <= min_d;
      max_q   <= max_d;
      cmin_q  <= cmin_d;
      cmax_q  <= cmax_d;
      n_q     <= n_d;
      trit_q  <= trit_d;
      acc_q   <= acc_d;
      pw_q    <= pw_d;
    end
  end

  assign row          = row_q;
  assign col          = col_q;
  assign found_string = found_q;
  assign busy         = busy_q;
  assign decode_done  = done_q;
  assign err          = err_q;

endmodule
